// File: rtl/cmd_sequencer.sv
`timescale 1ns/1ps
// cmd_sequencer
//
// Command controller for the vector coprocessor. A byte stream from the UART
// receiver carries a command byte, a 16-bit length N (MSB first), then N
// operand elements for memory A and N for memory B. Each element is
// max_pck+1 bytes, MSB first. Once both operand vectors are written, the HLS
// core is started. When it finishes, the result is handed to the transmit
// path. The next command is accepted only after the transmit path reports
// that it is idle again.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   rx_data, rx_valid    received byte and its one-cycle strobe
//   w_addr, w_data       operand element index and zero-extended element
//   we_a, we_b           one-cycle write strobes for operand memories A / B
//   op, n_elem           operation code and vector length to the core
//   ap_start, ap_done    core control
//   data_ready           one-cycle pulse that starts the transmit path
//   out_mode, max_pck    result format for the transmit path
//   tx_done              transmit path returned to idle (one-cycle pulse)
//   busy                 state is not IDLE
//   err                  one-cycle pulse when a command is aborted
//
// Handshakes
//   ap_start is held high for the whole RUN state (HLS ap_ctrl_hs) and drops
//   on the cycle after ap_done is sampled high. data_ready pulses for the
//   single SEND cycle. The sequencer then waits in WAIT_TX for a tx_done
//   pulse. ap_done outside RUN and tx_done outside WAIT_TX are ignored.
module cmd_sequencer #(
  parameter int unsigned MAX_ADDR    = 1024,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic [$clog2(MAX_ADDR)-1:0] w_addr,
  output logic [31:0]                 w_data,
  output logic                        we_a,
  output logic                        we_b,
  output logic [4:0]                  op,
  output logic [$clog2(MAX_ADDR):0]   n_elem,
  output logic                        ap_start,
  input  logic                        ap_done,
  output logic                        data_ready,
  output logic                        out_mode,
  output logic [1:0]                  max_pck,
  input  logic                        tx_done,
  output logic                        busy,
  output logic                        err
);

  localparam int AW = $clog2(MAX_ADDR);
  localparam int NW = AW + 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_TERM = TW'(TIMEOUT_CYC - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN_HI  = 3'd1;
  localparam logic [2:0] ST_LEN_LO  = 3'd2;
  localparam logic [2:0] ST_LOAD_A  = 3'd3;
  localparam logic [2:0] ST_LOAD_B  = 3'd4;
  localparam logic [2:0] ST_RUN     = 3'd5;
  localparam logic [2:0] ST_SEND    = 3'd6;
  localparam logic [2:0] ST_WAIT_TX = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [4:0]    op_q, op_d;
  logic          out_mode_q, out_mode_d;
  logic [1:0]    max_pck_q, max_pck_d;
  logic [7:0]    len_hi_q, len_hi_d;
  logic [NW-1:0] n_elem_q, n_elem_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic [31:0]   w_data_q, w_data_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic          we_a_q, we_a_d;
  logic          we_b_q, we_b_d;
  logic          last_q, last_d;    // the pending write closes its vector
  logic          err_q, err_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  logic [31:0]   len_full;
  logic [31:0]   next_word;
  logic          len_ok;
  logic          byte_last;
  logic          elem_last;
  logic          to_active;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    out_mode_d = out_mode_q;
    max_pck_d  = max_pck_q;
    len_hi_d   = len_hi_q;
    n_elem_d   = n_elem_q;
    w_data_d   = w_data_q;
    byte_cnt_d = byte_cnt_q;
    we_a_d     = 1'b0;
    we_b_d     = 1'b0;
    last_d     = 1'b0;
    err_d      = 1'b0;
    to_cnt_d   = '0;

    // The write strobed last cycle retires now. The address advances, or
    // rewinds to 0 when that write closed the A or B vector. Using the
    // post-retire address below keeps back-to-back 1-byte elements correct.
    w_addr_d = w_addr_q;
    if (we_a_q || we_b_q) begin
      w_addr_d = last_q ? '0 : w_addr_q + AW'(1);
    end

    elem_last = ({1'b0, w_addr_d} == n_elem_q - NW'(1));
    byte_last = (byte_cnt_q == max_pck_q);
    len_full  = {16'h0000, len_hi_q, rx_data};
    len_ok    = (len_full != 32'd0) && (len_full <= MAX_ADDR);
    // The first byte of an element clears the shift register.
    next_word = (byte_cnt_q == 2'd0) ? {24'h000000, rx_data}
                                     : {w_data_q[23:0], rx_data};

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          max_pck_d  = rx_data[7:6];
          out_mode_d = rx_data[5];
          op_d       = rx_data[4:0];
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (rx_valid) begin
          len_hi_d = rx_data;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (rx_valid) begin
          if (len_ok) begin
            n_elem_d   = len_full[NW-1:0];
            w_addr_d   = '0;
            byte_cnt_d = 2'd0;
            state_d    = ST_LOAD_A;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_LOAD_A: begin
        if (rx_valid) begin
          w_data_d = next_word;
          if (byte_last) begin
            we_a_d     = 1'b1;
            last_d     = elem_last;
            byte_cnt_d = 2'd0;
            // Move on at once so a B byte on the next cycle is not lost.
            // w_addr is rewound only when this write retires.
            if (elem_last) state_d = ST_LOAD_B;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      ST_LOAD_B: begin
        // Start the core only after the final B write has been strobed.
        if (we_b_q && last_q) begin
          state_d = ST_RUN;
        end else if (rx_valid) begin
          w_data_d = next_word;
          if (byte_last) begin
            we_b_d     = 1'b1;
            last_d     = elem_last;
            byte_cnt_d = 2'd0;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      ST_RUN: begin
        if (ap_done) state_d = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx_done) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Inter-byte timeout while a command is being received. A byte on the
    // terminal-count cycle restarts the count, so the byte wins the tie.
    to_active = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    if (to_active) begin
      if (rx_valid || (state_d != state_q)) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_TERM) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end

    if ((state_d != ST_LOAD_A) && (state_d != ST_LOAD_B)) byte_cnt_d = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      out_mode_q <= 1'b0;
      max_pck_q  <= '0;
      len_hi_q   <= '0;
      n_elem_q   <= '0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      byte_cnt_q <= '0;
      we_a_q     <= 1'b0;
      we_b_q     <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      out_mode_q <= out_mode_d;
      max_pck_q  <= max_pck_d;
      len_hi_q   <= len_hi_d;
      n_elem_q   <= n_elem_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      byte_cnt_q <= byte_cnt_d;
      we_a_q     <= we_a_d;
      we_b_q     <= we_b_d;
      last_q     <= last_d;
      err_q      <= err_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign w_addr     = w_addr_q;
  assign w_data     = w_data_q;
  assign we_a       = we_a_q;
  assign we_b       = we_b_q;
  assign op         = op_q;
  assign n_elem     = n_elem_q;
  assign out_mode   = out_mode_q;
  assign max_pck    = max_pck_q;
  assign err        = err_q;
  assign ap_start   = (state_q == ST_RUN);
  assign data_ready = (state_q == ST_SEND);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_cmd_sequencer;

  localparam int unsigned MAX_ADDR    = 16;
  localparam int unsigned TIMEOUT_CYC = 40;
  localparam int AW = $clog2(MAX_ADDR);
  localparam int NW = AW + 1;
  localparam int EW = 1 + AW + 32;   // {is_b, addr, data}

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          ap_done = 1'b0;
  logic          tx_done = 1'b0;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_data;
  logic          we_a, we_b;
  logic [4:0]    op;
  logic [NW-1:0] n_elem;
  logic          ap_start, data_ready, out_mode, busy, err;
  logic [1:0]    max_pck;

  always #5 clk = ~clk;

  cmd_sequencer #(.MAX_ADDR(MAX_ADDR), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .w_addr(w_addr), .w_data(w_data), .we_a(we_a), .we_b(we_b),
    .op(op), .n_elem(n_elem), .ap_start(ap_start), .ap_done(ap_done),
    .data_ready(data_ready), .out_mode(out_mode), .max_pck(max_pck),
    .tx_done(tx_done), .busy(busy), .err(err)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;
  int dr_cnt   = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0]   a_v[MAX_ADDR];
  logic [31:0]   b_v[MAX_ADDR];

  always @(negedge clk) begin : write_monitor
    logic [EW-1:0] exp_w;
    if (rst_n && err) err_cnt++;
    if (rst_n && data_ready) dr_cnt++;
    if (rst_n && (we_a || we_b)) begin
      n_checks++;
      if (we_a && we_b) begin
        $display("FAIL write_both got we_a=1 we_b=1 want one strobe");
      end else if (exp_q.size() == 0) begin
        $display("FAIL write_unexpected got b=%0b addr=%0d data=%h want none", we_b, w_addr, w_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({we_b, w_addr, w_data} !== exp_w)
          $display("FAIL write got b=%0b addr=%0d data=%h want b=%0b addr=%0d data=%h",
                   we_b, w_addr, w_data, exp_w[EW-1], exp_w[EW-2:32], exp_w[31:0]);
        else n_pass++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driver tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_header(input logic [7:0] cmd, input logic [15:0] len, input int gap);
    send_byte(cmd);
    idle(gap);
    send_byte(len[15:8]);
    idle(gap);
    send_byte(len[7:0]);
  endtask

  // Sends n elements of p+1 bytes, MSB first. The reference model queues
  // the write that each completed element must produce. No gap follows the
  // final B byte, so the caller sits on the cycle of the last write strobe.
  task automatic send_elems(input bit is_b, input int n, input int p, input int gap_lo, input int gap_hi);
    logic [31:0] val, mask;
    mask = 32'((64'd1 << (8 * (p + 1))) - 64'd1);
    for (int i = 0; i < n; i++) begin
      val = is_b ? b_v[i] : a_v[i];
      for (int j = p; j >= 0; j--) begin
        if (j == 0) exp_q.push_back({is_b, AW'(i), val & mask});
        send_byte(val[8*j +: 8]);
        if (!(is_b && (i == n - 1) && (j == 0))) idle(int'($urandom_range(gap_hi, gap_lo)));
      end
    end
  endtask

  task automatic check_launch(input logic [7:0] cmd, input int n);
    n_checks++;
    if (we_b !== 1'b1 || ap_start !== 1'b0)
      $display("FAIL launch_pre got we_b=%0b ap_start=%0b want 1 0", we_b, ap_start);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ap_start !== 1'b1 || busy !== 1'b1)
      $display("FAIL launch_start got ap_start=%0b busy=%0b want 1 1", ap_start, busy);
    else n_pass++;
    n_checks++;
    if ({max_pck, out_mode, op} !== cmd)
      $display("FAIL launch_cfg got %h want %h", {max_pck, out_mode, op}, cmd);
    else n_pass++;
    n_checks++;
    if (n_elem !== NW'(n)) $display("FAIL launch_n_elem got %0d want %0d", n_elem, n);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL launch_writes got %0d pending want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic finish_cmd();
    int dr0;
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    n_checks++;
    if (ap_start !== 1'b1 || busy !== 1'b1)
      $display("FAIL run_hold got ap_start=%0b busy=%0b want 1 1", ap_start, busy);
    else n_pass++;
    dr0 = dr_cnt;
    ap_done = 1'b1;
    @(negedge clk);
    ap_done = 1'b0;
    n_checks++;
    if (ap_start !== 1'b0 || data_ready !== 1'b1)
      $display("FAIL done_handoff got ap_start=%0b data_ready=%0b want 0 1", ap_start, data_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (data_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL handoff_pulse got data_ready=%0b busy=%0b want 0 1", data_ready, busy);
    else n_pass++;
    ap_done = 1'b1;
    @(negedge clk);
    ap_done = 1'b0;
    idle(2);
    n_checks++;
    if (dr_cnt - dr0 !== 1 || busy !== 1'b1)
      $display("FAIL wait_tx_hold got pulses=%0d busy=%0b want 1 1", dr_cnt - dr0, busy);
    else n_pass++;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL tx_release got busy=%0b want 0", busy);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b0 || ap_start !== 1'b0 || data_ready !== 1'b0)
      $display("FAIL reset_ctrl got %b want 0000", {busy, err, ap_start, data_ready});
    else n_pass++;
    n_checks++;
    if (w_addr !== '0 || w_data !== 32'h0 || we_a !== 1'b0 || we_b !== 1'b0)
      $display("FAIL reset_write got addr=%0d data=%h we=%b want 0", w_addr, w_data, {we_a, we_b});
    else n_pass++;
    n_checks++;
    if (op !== 5'd0 || n_elem !== '0 || out_mode !== 1'b0 || max_pck !== 2'd0)
      $display("FAIL reset_cfg got op=%0d n=%0d mode=%0b pck=%0d want 0", op, n_elem, out_mode, max_pck);
    else n_pass++;
    rst_n = 1'b1;
    idle(2);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_release got busy=%0b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    a_v[0] = 32'h01020304; a_v[1] = 32'h05060708;
    b_v[0] = 32'h0A0B0C0D; b_v[1] = 32'h0E0F1011;
    send_header(8'hC3, 16'd2, 0);
    send_elems(1'b0, 2, 3, 0, 0);
    send_elems(1'b1, 2, 3, 0, 0);
    check_launch(8'hC3, 2);
    finish_cmd();
  endtask

  task automatic test_scalar();
    a_v[0] = 32'h000000FF;
    b_v[0] = 32'h00000080;
    send_header(8'h25, 16'd1, 1);
    send_elems(1'b0, 1, 0, 1, 1);
    send_elems(1'b1, 1, 0, 1, 1);
    check_launch(8'h25, 1);
    finish_cmd();
  endtask

  task automatic test_illegal_len();
    logic [15:0] bad[3];
    int e0;
    bad = '{16'd0, 16'(MAX_ADDR + 1), 16'h0100};
    for (int k = 0; k < 3; k++) begin
      e0 = err_cnt;
      send_header(8'hC1, bad[k], 0);
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0)
        $display("FAIL bad_len_abort len=%0d got err=%0b busy=%0b want 1 0", bad[k], err, busy);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (err !== 1'b0 || err_cnt - e0 !== 1)
        $display("FAIL bad_len_pulse len=%0d got err=%0b pulses=%0d want 0 1", bad[k], err, err_cnt - e0);
      else n_pass++;
    end
  endtask

  task automatic test_max_len();
    logic [7:0] cmd;
    cmd = {2'b00, 1'($urandom), 5'($urandom)};
    for (int i = 0; i < MAX_ADDR; i++) begin
      a_v[i] = $urandom;
      b_v[i] = $urandom;
    end
    send_header(cmd, 16'(MAX_ADDR), 0);
    send_elems(1'b0, MAX_ADDR, 0, 0, 0);
    send_elems(1'b1, MAX_ADDR, 0, 0, 0);
    check_launch(cmd, MAX_ADDR);
    finish_cmd();
  endtask

  task automatic test_stall();
    int e0;
    a_v[0] = $urandom; a_v[1] = $urandom;
    b_v[0] = 32'hDEADBEEF;
    send_header(8'hE7, 16'd2, 1);
    send_elems(1'b0, 2, 3, 0, 1);
    send_byte(b_v[0][31:24]);
    send_byte(b_v[0][23:16]);
    e0 = err_cnt;
    idle(TIMEOUT_CYC - 1);
    n_checks++;
    if (busy !== 1'b1 || err_cnt != e0)
      $display("FAIL stall_early got busy=%0b pulses=%0d want 1 0", busy, err_cnt - e0);
    else n_pass++;
    idle(1);
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b1)
      $display("FAIL stall_abort got busy=%0b err=%0b want 0 1", busy, err);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (err_cnt - e0 !== 1 || exp_q.size() != 0)
      $display("FAIL stall_pulse got pulses=%0d pending=%0d want 1 0", err_cnt - e0, exp_q.size());
    else n_pass++;
    send_byte(8'h41);
    idle(TIMEOUT_CYC);
    n_checks++;
    if (busy !== 1'b0 || err !== 1'b1)
      $display("FAIL stall_len_abort got busy=%0b err=%0b want 0 1", busy, err);
    else n_pass++;
    @(negedge clk);
    a_v[0] = $urandom; b_v[0] = $urandom;
    send_header(8'h4A, 16'd1, 0);
    send_elems(1'b0, 1, 1, 0, 2);
    send_elems(1'b1, 1, 1, 0, 2);
    check_launch(8'h4A, 1);
    finish_cmd();
  endtask

  task automatic test_tie();
    int e0;
    e0 = err_cnt;
    for (int i = 0; i < 2; i++) begin
      a_v[i] = $urandom;
      b_v[i] = $urandom;
    end
    send_header(8'h52, 16'd2, TIMEOUT_CYC - 1);
    send_elems(1'b0, 2, 1, TIMEOUT_CYC - 1, TIMEOUT_CYC - 1);
    send_elems(1'b1, 2, 1, TIMEOUT_CYC - 1, TIMEOUT_CYC - 1);
    n_checks++;
    if (err_cnt != e0) $display("FAIL tie_no_abort got pulses=%0d want 0", err_cnt - e0);
    else n_pass++;
    check_launch(8'h52, 2);
    finish_cmd();
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    int p, n, e0;
    for (int r = 0; r < 5; r++) begin
      e0 = err_cnt;
      p = int'($urandom_range(3, 0));
      n = int'($urandom_range(MAX_ADDR, 1));
      cmd = {2'(p), 1'($urandom), 5'($urandom)};
      for (int i = 0; i < MAX_ADDR; i++) begin
        a_v[i] = $urandom;
        b_v[i] = $urandom;
      end
      send_header(cmd, 16'(n), int'($urandom_range(2, 0)));
      send_elems(1'b0, n, p, 0, 2);
      send_elems(1'b1, n, p, 0, 2);
      check_launch(cmd, n);
      finish_cmd();
      n_checks++;
      if (err_cnt != e0) $display("FAIL random_no_err round=%0d got pulses=%0d want 0", r, err_cnt - e0);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      a_v[i] = $urandom;
      b_v[i] = $urandom | 32'h00000101;
    end
    send_header(8'h5E, 16'd3, 0);
    send_elems(1'b0, 3, 1, 0, 1);
    send_elems(1'b1, 3, 1, 0, 1);
    check_launch(8'h5E, 3);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || ap_start !== 1'b0 || data_ready !== 1'b0 || err !== 1'b0)
      $display("FAIL async_reset_ctrl got %b want 0000", {busy, ap_start, data_ready, err});
    else n_pass++;
    n_checks++;
    if (op !== 5'd0 || n_elem !== '0 || out_mode !== 1'b0 || max_pck !== 2'd0 ||
        w_data !== 32'h0 || w_addr !== '0)
      $display("FAIL async_reset_regs got op=%0d n=%0d data=%h want 0", op, n_elem, w_data);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL async_reset_release got busy=%0b want 0", busy);
    else n_pass++;
    a_v[0] = $urandom; b_v[0] = $urandom;
    send_header(8'h9C, 16'd1, 0);
    send_elems(1'b0, 1, 2, 0, 1);
    send_elems(1'b1, 1, 2, 0, 1);
    check_launch(8'h9C, 1);
    finish_cmd();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_scalar();
    test_illegal_len();
    test_max_len();
    test_stall();
    test_tie();
    test_random();
    test_reset_mid();
    idle(3);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL final_queue got %0d pending want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Top-level command controller for the vector coprocessor. It parses a byte stream from the UART receiver, assembles operand elements into the A and B operand memories, and starts the HLS vector core through its `ap_start`/`ap_done` handshake. It then hands the result memory to the transmit path by pulsing `data_ready` with the configured `out_mode` and `max_pck`, and waits for that path to finish before accepting the next command.

## Interface
- `MAX_ADDR`, 1024 — depth of the A, B and result memories, in elements.
- `TIMEOUT_CYC`, 1_000_000 — number of idle `clk` cycles between received bytes that aborts a partially received command.
- `clk` in 1 — single clock; all logic is on its rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `rx_data` in 8 — received byte.
- `rx_valid` in 1 — one-cycle strobe; `rx_data` is valid on this cycle.
- `w_addr` out `$clog2(MAX_ADDR)` — operand write address (element index).
- `w_data` out 32 — assembled operand element, zero-extended.
- `we_a` out 1 — write strobe for operand memory A.
- `we_b` out 1 — write strobe for operand memory B.
- `op` out 5 — operation code to the core.
- `n_elem` out `$clog2(MAX_ADDR)+1` — vector length to the core.
- `ap_start` out 1 — core start; follows HLS `ap_ctrl_hs` semantics.
- `ap_done` in 1 — core completion.
- `data_ready` out 1 — one-cycle pulse that starts the transmit path.
- `out_mode` out 1 — 1 means a scalar result (one word is sent).
- `max_pck` out 2 — bytes per element minus 1.
- `tx_done` in 1 — one-cycle pulse when the transmit path has returned to idle.
- `busy` out 1 — high whenever the state is not IDLE.
- `err` out 1 — one-cycle pulse when a command is aborted.

## Operation
- **Command byte:** `[7:6]` is `max_pck`, `[5]` is `out_mode`, `[4:0]` is `op`. All three are latched on receipt and held until the next command byte.
- **Length:** two bytes, MSB first, giving N.
  - Legal range is 1..`MAX_ADDR`.
  - N is latched into `n_elem`.
  - An illegal N causes an abort.
- **Payload:** N elements of A, then N elements of B. Each element is `max_pck`+1 bytes, MSB first.
- **States and transitions:**
  - IDLE → LEN_HI on `rx_valid`; this byte is the command byte.
  - LEN_HI → LEN_LO on `rx_valid`.
  - LEN_LO → LOAD_A on `rx_valid` if N is legal; otherwise abort.
  - LOAD_A → LOAD_B after the N-th A element is written.
  - LOAD_B → RUN after the N-th B element is written.
  - RUN → SEND when `ap_done` is 1.
  - SEND → WAIT_TX unconditionally.
  - WAIT_TX → IDLE on `tx_done`.
- **Element assembly:**
  - The shift register is cleared at the start of each element.
  - Each byte shifts in as `w_data <= {w_data[23:0], rx_data}`.
  - A byte counter runs 0..`max_pck`.
  - When the final byte of an element arrives, `we_a` or `we_b` is high for exactly one cycle, on the cycle after that byte's `rx_valid`. `w_data` and `w_addr` are stable during the strobe.
  - `w_addr` increments after each write.
  - `w_addr` is reset to 0 on entering LOAD_A and on entering LOAD_B.
- **Core handshake:** `ap_start` = (state == RUN). It is deasserted on the cycle after `ap_done` is sampled high.
- **Transmit handoff:** `data_ready` is high only in SEND, for exactly 1 cycle.
- **Abort:**
  - Triggers: an illegal length, or the timeout counter reaching `TIMEOUT_CYC`-1 while in LEN_HI, LEN_LO, LOAD_A or LOAD_B.
  - Effect: `err` pulses for 1 cycle and the state returns to IDLE.
  - Operand memory contents are left as written.
- **Timeout counter:** cleared on every `rx_valid` and on every state change. It is inactive in IDLE, RUN, SEND and WAIT_TX.
- **Bytes outside loading:** `rx_valid` in RUN, SEND or WAIT_TX is ignored and causes no state change.
- **Reset:** while `rst_n` is 0, the state is IDLE and every output is 0, including `w_addr`, `w_data`, `op`, `n_elem`, `out_mode` and `max_pck`. A reset in mid-command discards the command entirely.

## Timing
- Latency from a byte to the state register is 1 cycle: `rx_valid` at edge k gives the new state visible after edge k+1.
- Write strobe: the final byte of an element arrives at cycle k; `we_*` is high at cycle k+1.
- With `rx_valid` at cycle k on the final B element:
  - `we_b` is high at k+1.
  - The state is RUN and `ap_start` is 1 at k+2.
- `ap_done` sampled at cycle k gives `ap_start` = 0 and `data_ready` = 1 at k+1, and `data_ready` = 0 at k+2.
- If `rx_valid` and the timeout terminal count occur on the same cycle, `rx_valid` wins and no abort occurs.
- Back-to-back `rx_valid` on consecutive cycles must be accepted with no loss of bytes.
- `tx_done` arriving while not in WAIT_TX is ignored.
- `ap_done` arriving while not in RUN is ignored.

## Test plan
- **Basic 4-byte command:** send cmd 0xC3, len 0x00 0x02, A = 0x01020304, 0x05060708, B = 0x0A0B0C0D, 0x0E0F1011.
  - Required: `we_a` at `w_addr` 0 then 1 with those words; `we_b` likewise.
  - Required: `op` = 3, `max_pck` = 3, `n_elem` = 2.
  - Required: `ap_start` rises 1 cycle after the last `we_b`.
- **1-byte elements, scalar mode:** cmd 0x25, len 1, A = 0xFF, B = 0x80.
  - Required: `w_data` = 0x000000FF then 0x00000080.
  - Required: `out_mode` = 1, `max_pck` = 0.
  - Then: `ap_done` pulse → `data_ready` high for exactly 1 cycle; `tx_done` → `busy` = 0.
- **Illegal length:** len 0 → `err` pulse, IDLE, no `we_*`. Len `MAX_ADDR`+1 → same response.
- **Stall:** stall for `TIMEOUT_CYC` cycles mid-element of B → `err` pulse, IDLE. A following complete command then executes normally.
- **Timeout tie-break:** a byte arriving exactly on the terminal-count cycle → no abort.
- **Reset mid-operation:** assert `rst_n` = 0 during RUN → all outputs 0 asynchronously. Bytes received during RUN cause no state change.
